// File: rtl/moving_sum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : moving_sum_pkg
//  Purpose  : Shared constants and helpers for the moving_sum block and its
//             circular sample buffer.
//             - clog2          : ceiling log2 usable in parameter expressions
//             - acc_w          : accumulator / output width for a W x D window
//             - sext64         : sign-extend the low bits of a 64-bit word
//  Revision : 1.0 - initial release
// ============================================================================
package moving_sum_pkg;

    // Widest value the sign-extension helper handles.
    localparam int c_SEXT_MAX_W = 64;

    // Ceiling log2. Returns 0 for value <= 1. Bit 31 is never tested, so the
    // loop cannot hit the negative 1<<31 case.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A window of D signed W-bit samples needs clog2(D) extra bits of headroom.
    function automatic int acc_w(input int w, input int d);
        return w + clog2(d);
    endfunction

    // Treat bit (from_w-1) of val as the sign bit and replicate it upward.
    // Callers cast the result down to the width they need.
    function automatic logic [c_SEXT_MAX_W-1:0] sext64(
        input logic [c_SEXT_MAX_W-1:0] val,
        input int                      from_w
    );
        logic signed [c_SEXT_MAX_W-1:0] w_tmp;
        w_tmp = $signed(val << (c_SEXT_MAX_W - from_w));
        return w_tmp >>> (c_SEXT_MAX_W - from_w);
    endfunction

endpackage : moving_sum_pkg
`default_nettype wire

// File: rtl/moving_sum_buf.sv
`default_nettype none
// ============================================================================
//  Module   : moving_sum_buf
//  Purpose  : Sample-enabled D-entry circular buffer. It advances only on
//             accepted samples and produces the sample written D accepted
//             samples earlier, read before the same-cycle write. During
//             warm-up the tap reads as zero, so stale contents never escape.
//  Ports    :
//      clk          in   clock, rising edge
//      reset        in   synchronous active-high reset
//      i_en         in   sample accept strobe
//      i_din        in   sample to store (W bits)
//      o_tap        out  mem[wp] once full, else 0 (W bits)
//      o_full       out  D samples accepted since reset
//      o_full_next  out  fill state after the current edge
//  Revision : 1.0 - initial release
// ============================================================================
module moving_sum_buf
    import moving_sum_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_tap,
    output logic         o_full,
    output logic         o_full_next
);

    localparam int                 c_PTR_W = clog2(D);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(D - 1);

    logic [W-1:0]       r_mem [D];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_cnt;
    logic               r_full;
    logic               w_wr;

    // Samples offered while reset is high must not land in the buffer.
    assign w_wr = i_en & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (i_en) begin
            r_wp <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
            // The fill counter freezes once the window has filled.
            if (!r_full) begin
                if (r_cnt == c_LAST) begin
                    r_full <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Storage has no reset: warm-up masking makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_din;
        end
    end

    assign o_tap       = r_full ? r_mem[r_wp] : '0;
    assign o_full      = r_full;
    assign o_full_next = r_full | (i_en & (r_cnt == c_LAST));

endmodule : moving_sum_buf
`default_nettype wire

// File: rtl/moving_sum.sv
`default_nettype none
// ============================================================================
//  Module   : moving_sum
//  Purpose  : Sliding-window summer over the last D accepted samples,
//             built as a recursive comb/integrator: acc += x[n] - x[n-D].
//             One cycle of latency, full rate with back-to-back samples.
//  Build option:
//      MOVING_SUM_AVG_EN  - when defined, dout is the rounded window mean
//                           (acc + 2^(L-1)) >>> L with L = clog2(D), and
//                           D must be a power of two.
//  Ports    :
//      clk       in   clock, rising edge
//      reset     in   synchronous active-high reset
//      din       in   signed sample (W bits)
//      din_vld   in   sample strobe
//      dout      out  signed window sum or mean (W+clog2(D) bits)
//      dout_vld  out  one-cycle strobe per accepted sample once full
//      full      out  D samples accepted since reset
//  Revision : 1.0 - initial release
// ============================================================================
module moving_sum
    import moving_sum_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic signed [W-1:0]            din,
    input  logic                           din_vld,
    output logic signed [acc_w(W, D)-1:0]  dout,
    output logic                           dout_vld,
    output logic                           full
);

    localparam int c_ACC_W  = acc_w(W, D);
    localparam int c_LOG2_D = clog2(D);

    if ((D < 2) || (D > 4096)) begin : g_bad_depth
        $error("moving_sum: D must lie in 2..4096");
    end

    logic [W-1:0]               w_tap;
    logic                       w_full_next;
    logic signed [c_ACC_W-1:0]  w_din_ext;
    logic signed [c_ACC_W-1:0]  w_tap_ext;
    logic signed [c_ACC_W-1:0]  w_acc_next;
    logic signed [c_ACC_W-1:0]  w_dout_next;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic signed [c_ACC_W-1:0]  r_dout;
    logic                       r_dout_vld;

    moving_sum_buf #(
        .W (W),
        .D (D)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_en        (din_vld),
        .i_din       (din),
        .o_tap       (w_tap),
        .o_full      (full),
        .o_full_next (w_full_next)
    );

    assign w_din_ext  = c_ACC_W'(sext64({{(c_SEXT_MAX_W-W){1'b0}}, din}, W));
    assign w_tap_ext  = c_ACC_W'(sext64({{(c_SEXT_MAX_W-W){1'b0}}, w_tap}, W));
    // Window of D W-bit samples always fits c_ACC_W bits: no saturation.
    assign w_acc_next = r_acc + w_din_ext - w_tap_ext;

`ifdef MOVING_SUM_AVG_EN
    if ((1 << c_LOG2_D) != D) begin : g_bad_pow2
        $error("moving_sum: averaging needs D to be a power of two");
    end

    localparam logic signed [c_ACC_W-1:0] c_HALF = c_ACC_W'(1) << (c_LOG2_D - 1);

    // Adding half an LSB cannot overflow: the largest window sum is
    // 2^(c_ACC_W-1) - D, leaving room for D/2.
    logic signed [c_ACC_W-1:0] w_rnd;
    assign w_rnd       = w_acc_next + c_HALF;
    assign w_dout_next = w_rnd >>> c_LOG2_D;
`else
    assign w_dout_next = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= din_vld & w_full_next;
            if (din_vld) begin
                r_acc  <= w_acc_next;
                r_dout <= w_dout_next;
            end
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

endmodule : moving_sum
`default_nettype wire

// File: tb/tb_moving_sum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_moving_sum
//  Purpose  : Self-checking bench for moving_sum. Two instances share one
//             input stream: depth 4, and depth 5 (8 when averaging is built
//             in). Expected outputs come from a queue of accepted samples.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_moving_sum;

    localparam int W  = 16;
    localparam int DA = 4;
`ifdef MOVING_SUM_AVG_EN
    localparam int DB = 8;
`else
    localparam int DB = 5;
`endif
    localparam int AWA = W + $clog2(DA);
    localparam int AWB = W + $clog2(DB);

    logic                   clk;
    logic                   reset;
    logic signed [W-1:0]    din;
    logic                   din_vld;
    logic signed [AWA-1:0]  dout_a;
    logic                   dout_vld_a;
    logic                   full_a;
    logic signed [AWB-1:0]  dout_b;
    logic                   dout_vld_b;
    logic                   full_b;

    moving_sum #(.W(W), .D(DA)) u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout_a),
        .dout_vld (dout_vld_a),
        .full     (full_a)
    );

    moving_sum #(.W(W), .D(DB)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout_b),
        .dout_vld (dout_vld_b),
        .full     (full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     total;
    int     bad;
    int     hist[$];        // samples accepted since the last reset
    longint exp_dout_a, exp_dout_b;
    bit     exp_vld_a, exp_vld_b;
    bit     exp_full_a, exp_full_b;

    typedef struct {
        bit     rst;
        bit     vld;
        int     din;
        longint exp_sum;
        bit     exp_vld;
        bit     exp_full;
    } vec_t;

    vec_t tbl[$];

    // Sum of the newest min(count, d) accepted samples.
    function automatic longint win_sum(int d);
        longint s;
        int     n;
        s = 0;
        n = hist.size();
        for (int i = 0; i < d && i < n; i++) begin
            s += hist[n-1-i];
        end
        return s;
    endfunction

    // What dout should show for a given window sum.
    function automatic longint shape(longint s, int d);
`ifdef MOVING_SUM_AVG_EN
        int l;
        l = $clog2(d);
        return (s + (longint'(1) << (l - 1))) >>> l;
`else
        if (d < 0) return 0;
        return s;
`endif
    endfunction

    task automatic check(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, and
    // compare both instances against it.
    task automatic cycle(bit r, bit v, int x);
        @(negedge clk);
        reset   = r;
        din_vld = v;
        din     = W'(x);
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            exp_dout_a = 0; exp_vld_a = 0; exp_full_a = 0;
            exp_dout_b = 0; exp_vld_b = 0; exp_full_b = 0;
        end else if (v) begin
            hist.push_back(int'($signed(W'(x))));
            if (hist.size() > 64) void'(hist.pop_front());
            exp_full_a = exp_full_a || (hist.size() >= DA);
            exp_full_b = exp_full_b || (hist.size() >= DB);
            exp_dout_a = shape(win_sum(DA), DA);
            exp_dout_b = shape(win_sum(DB), DB);
            exp_vld_a  = exp_full_a;
            exp_vld_b  = exp_full_b;
        end else begin
            exp_vld_a = 0;
            exp_vld_b = 0;
        end
        check("mdl_dout_a", longint'(dout_a), exp_dout_a);
        check("mdl_vld_a",  longint'(dout_vld_a), longint'(exp_vld_a));
        check("mdl_full_a", longint'(full_a), longint'(exp_full_a));
        check("mdl_dout_b", longint'(dout_b), exp_dout_b);
        check("mdl_vld_b",  longint'(dout_vld_b), longint'(exp_vld_b));
        check("mdl_full_b", longint'(full_b), longint'(exp_full_b));
    endtask

    task automatic add(bit r, bit v, int x, longint s, bit ev, bit ef);
        vec_t e;
        e.rst = r; e.vld = v; e.din = x; e.exp_sum = s; e.exp_vld = ev; e.exp_full = ef;
        tbl.push_back(e);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; din_vld = 1'b0; din = '0;
        exp_dout_a = 0; exp_dout_b = 0;
        exp_vld_a = 0; exp_vld_b = 0; exp_full_a = 0; exp_full_b = 0;

        // Reset state
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("reset_dout", longint'(dout_a), 0);
        check("reset_vld",  longint'(dout_vld_a), 0);
        check("reset_full", longint'(full_a), 0);

        // ---- Directed table for the depth-4 instance (window sums) ----
        // ramp 1..6
        add(0,1,1,1,0,0);  add(0,1,2,3,0,0);  add(0,1,3,6,0,0);
        add(0,1,4,10,1,1); add(0,1,5,14,1,1); add(0,1,6,18,1,1);
        // reset with a sample offered in the same cycle: sample ignored
        add(1,1,99,0,0,0);
        // extremes: no wrap in 18 bits
        add(0,1,-32768,-32768,0,0); add(0,1,-32768,-65536,0,0);
        add(0,1,-32768,-98304,0,0); add(0,1,-32768,-131072,1,1);
        add(0,1,32767,-65537,1,1);  add(0,1,32767,-2,1,1);
        add(0,1,32767,65533,1,1);   add(0,1,32767,131068,1,1);
        // gapped valid: outputs hold through gaps
        add(1,0,0,0,0,0);
        add(0,1,1,1,0,0); add(0,0,7,1,0,0); add(0,0,7,1,0,0);
        add(0,1,2,3,0,0); add(0,1,3,6,0,0); add(0,0,7,6,0,0);
        add(0,1,4,10,1,1); add(0,0,7,10,0,1);
        // build to 40, then reset mid-stream and warm up again
        add(0,1,10,19,1,1); add(0,1,10,27,1,1); add(0,1,10,34,1,1); add(0,1,10,40,1,1);
        add(1,1,7,0,0,0);
        add(0,1,1,1,0,0); add(0,1,2,3,0,0); add(0,1,3,6,0,0); add(0,1,4,10,1,1);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rst, tbl[i].vld, tbl[i].din);
            check($sformatf("tbl%0d_dout", i), longint'(dout_a), shape(tbl[i].exp_sum, DA));
            check($sformatf("tbl%0d_vld", i),  longint'(dout_vld_a), longint'(tbl[i].exp_vld));
            check($sformatf("tbl%0d_full", i), longint'(full_a), longint'(tbl[i].exp_full));
        end

        // ---- Wrap: stream 0..19 into both instances ----
        cycle(1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, i);
        begin
            longint s;
            s = 0;
            for (int i = 20 - DB; i < 20; i++) s += i;
            check("wrap_dout_b", longint'(dout_b), shape(s, DB));
            check("wrap_vld_b",  longint'(dout_vld_b), 1);
        end
        check("wrap_dout_a", longint'(dout_a), shape(16 + 17 + 18 + 19, DA));

        // ---- Rounding corner cases (raw sums 11 and -5) ----
        cycle(1, 0, 0);
        cycle(0, 1, 1); cycle(0, 1, 2); cycle(0, 1, 3); cycle(0, 1, 5);
        check("rnd_pos", longint'(dout_a), shape(11, DA));
        cycle(1, 0, 0);
        cycle(0, 1, -1); cycle(0, 1, -1); cycle(0, 1, -1); cycle(0, 1, -2);
        check("rnd_neg", longint'(dout_a), shape(-5, DA));

        // ---- Randomized stream with occasional resets ----
        for (int i = 0; i < 600; i++) begin
            bit r, v;
            int x;
            r = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       x = -32768;
                1:       x = 32767;
                default: x = int'($urandom_range(0, 65535)) - 32768;
            endcase
            cycle(r, v, x);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_moving_sum
`default_nettype wire
